// File: rtl/write_address_counter_if.sv
// Write-side buffer handshake bundle: producer/consumer requests in, accept
// strobes, write address/strobes and occupancy flags out.
interface write_address_counter_if #(
  parameter int DEPTH = 15,
  parameter int AW    = 4
);
  logic             WriteEn;
  logic             ReadEn;
  logic [AW-1:0]    WriteReg;
  logic [DEPTH-1:0] WriteSel;
  logic             WrAccept;
  logic             RdAccept;
  logic [AW-1:0]    Count;
  logic             Full;
  logic             Empty;
  logic             Overflow;

  modport master (
    output WriteEn, ReadEn,
    input  WriteReg, WriteSel, WrAccept, RdAccept, Count, Full, Empty, Overflow
  );

  modport slave (
    input  WriteEn, ReadEn,
    output WriteReg, WriteSel, WrAccept, RdAccept, Count, Full, Empty, Overflow
  );
endinterface

// File: rtl/write_address_counter.sv
// Write-side one-hot ring pointer, encoded write address and shared fill count
// for the 15-entry register buffer.
module write_address_counter #(
  parameter int DEPTH = 15,
  parameter int AW    = 4
) (
  input logic                     clk,
  input logic                     rst,
  write_address_counter_if.slave  bus
);

  logic [DEPTH-1:0] ring;
  logic [AW-1:0]    writeReg;
  logic [AW-1:0]    count;
  logic [AW-1:0]    nextCount;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             wrAccept;
  logic             rdAccept;
  logic             ringValid;

  // No bypass: a write into an empty buffer cannot be read in the same cycle,
  // and a read from a full buffer does not make room for a same-cycle write.
  assign wrAccept = bus.WriteEn & ~full;
  assign rdAccept = bus.ReadEn & ~empty;

  assign ringValid = (ring != '0) && ((ring & (ring - DEPTH'(1))) == '0);

  always_comb begin
    nextCount = count;
    if (wrAccept && !rdAccept) begin
      nextCount = count + AW'(1);
    end else if (!wrAccept && rdAccept) begin
      nextCount = count - AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring     <= DEPTH'(1);
      writeReg <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      // A corrupted ring is forced back to slot 0; occupancy keeps tracking.
      if (!ringValid) begin
        ring     <= DEPTH'(1);
        writeReg <= '0;
      end else if (wrAccept) begin
        ring     <= {ring[DEPTH-2:0], ring[DEPTH-1]};
        writeReg <= (writeReg == AW'(DEPTH - 1)) ? '0 : writeReg + AW'(1);
      end
      count <= nextCount;
      full  <= (nextCount == AW'(DEPTH));
      empty <= (nextCount == '0);
      if (bus.WriteEn && full) begin
        overflow <= 1'b1;
      end
    end
  end

  assign bus.WriteSel = ring & {DEPTH{wrAccept}};
  assign bus.WrAccept = wrAccept;
  assign bus.RdAccept = rdAccept;
  assign bus.WriteReg = writeReg;
  assign bus.Count    = count;
  assign bus.Full     = full;
  assign bus.Empty    = empty;
  assign bus.Overflow = overflow;

endmodule

// File: tb/tb_write_address_counter.sv
// Self-checking bench for write_address_counter: directed boundary scenarios
// plus randomized traffic against an occupancy/address model.
module tb_write_address_counter;

  logic clk = 1'b0;
  logic rst;

  write_address_counter_if bus ();

  write_address_counter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: number of entries held, next write slot, sticky overflow.
  int   mCount = 0;
  int   mAddr  = 0;
  logic mOvf   = 1'b0;

  logic        expWrAcc, expRdAcc, obsWrAcc, obsRdAcc;
  logic [14:0] expSel, obsSel;

  // Drive one cycle, capture the combinational outputs mid-cycle, then advance
  // the model across the rising edge and settle on the falling edge.
  task automatic applyStimulus(input logic we, input logic re, input logic r);
    rst         = r;
    bus.WriteEn = we;
    bus.ReadEn  = re;
    #1;
    expWrAcc = we && (mCount != 15);
    expRdAcc = re && (mCount != 0);
    expSel   = expWrAcc ? 15'(1 << mAddr) : 15'h0;
    obsWrAcc = bus.WrAccept;
    obsRdAcc = bus.RdAccept;
    obsSel   = bus.WriteSel;
    @(posedge clk);
    if (r) begin
      mCount = 0;
      mAddr  = 0;
      mOvf   = 1'b0;
    end else begin
      if (we && mCount == 15) mOvf = 1'b1;
      mCount = mCount + int'(expWrAcc) - int'(expRdAcc);
      if (expWrAcc) mAddr = (mAddr + 1) % 15;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checks += 5;
    if (bus.WriteReg !== 4'd0) begin errors++; $display("[TB] FAIL reset_writereg: got %0d expected 0", bus.WriteReg); end
    if (bus.Count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.Count); end
    if (bus.Empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", bus.Empty); end
    if (bus.Full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", bus.Full); end
    if (bus.Overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", bus.Overflow); end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checks++;
    if (obsSel !== 15'h0001) begin errors++; $display("[TB] FAIL reset_first_sel: got %h expected 0001", obsSel); end
  endtask

  task automatic test_fill_wrap();
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checks += 2;
      if (obsSel !== expSel) begin errors++; $display("[TB] FAIL fill_sel[%0d]: got %h expected %h", i, obsSel, expSel); end
      if (obsWrAcc !== 1'b1) begin errors++; $display("[TB] FAIL fill_wracc[%0d]: got %b expected 1", i, obsWrAcc); end
    end
    checks += 3;
    if (bus.Count !== 4'd15) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 15", bus.Count); end
    if (bus.Full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full: got %b expected 1", bus.Full); end
    if (bus.WriteReg !== 4'd0) begin errors++; $display("[TB] FAIL fill_wrap_reg: got %0d expected 0", bus.WriteReg); end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checks += 4;
    if (obsWrAcc !== 1'b0) begin errors++; $display("[TB] FAIL over_wracc: got %b expected 0", obsWrAcc); end
    if (obsSel !== 15'h0) begin errors++; $display("[TB] FAIL over_sel: got %h expected 0000", obsSel); end
    if (bus.Overflow !== 1'b1) begin errors++; $display("[TB] FAIL over_flag: got %b expected 1", bus.Overflow); end
    if (bus.Count !== 4'd15) begin errors++; $display("[TB] FAIL over_count: got %0d expected 15", bus.Count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.Count !== 4'(14 - i)) begin errors++; $display("[TB] FAIL drain_count[%0d]: got %0d expected %0d", i, bus.Count, 14 - i); end
    end
    checks += 2;
    if (bus.Empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 1", bus.Empty); end
    if (bus.WriteReg !== 4'd0) begin errors++; $display("[TB] FAIL drain_reg: got %0d expected 0", bus.WriteReg); end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checks += 2;
    if (obsRdAcc !== 1'b0) begin errors++; $display("[TB] FAIL under_rdacc: got %b expected 0", obsRdAcc); end
    if (bus.Count !== 4'd0) begin errors++; $display("[TB] FAIL under_count: got %0d expected 0", bus.Count); end
  endtask

  task automatic test_simultaneous();
    applyStimulus(1'b1, 1'b1, 1'b0);
    checks += 4;
    if (obsWrAcc !== 1'b1) begin errors++; $display("[TB] FAIL simE_wracc: got %b expected 1", obsWrAcc); end
    if (obsRdAcc !== 1'b0) begin errors++; $display("[TB] FAIL simE_rdacc: got %b expected 0", obsRdAcc); end
    if (bus.Count !== 4'd1) begin errors++; $display("[TB] FAIL simE_count: got %0d expected 1", bus.Count); end
    if (bus.WriteReg !== 4'd1) begin errors++; $display("[TB] FAIL simE_reg: got %0d expected 1", bus.WriteReg); end
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checks += 4;
    if (obsWrAcc !== 1'b0) begin errors++; $display("[TB] FAIL simF_wracc: got %b expected 0", obsWrAcc); end
    if (obsRdAcc !== 1'b1) begin errors++; $display("[TB] FAIL simF_rdacc: got %b expected 1", obsRdAcc); end
    if (bus.Count !== 4'd14) begin errors++; $display("[TB] FAIL simF_count: got %0d expected 14", bus.Count); end
    if (bus.WriteReg !== 4'd0) begin errors++; $display("[TB] FAIL simF_reg: got %0d expected 0", bus.WriteReg); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checks += 2;
      if ($countones(obsSel) != 1) begin errors++; $display("[TB] FAIL stream_onehot[%0d]: got %h expected one bit set", i, obsSel); end
      if (bus.Count !== 4'd5) begin errors++; $display("[TB] FAIL stream_count[%0d]: got %0d expected 5", i, bus.Count); end
    end
    checks++;
    if (bus.WriteReg !== 4'd10) begin errors++; $display("[TB] FAIL stream_reg: got %0d expected 10", bus.WriteReg); end
  endtask

  task automatic test_reset_midstream();
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checks += 2;
    if (bus.Count !== 4'd9) begin errors++; $display("[TB] FAIL mid_setup_count: got %0d expected 9", bus.Count); end
    if (bus.WriteReg !== 4'd12) begin errors++; $display("[TB] FAIL mid_setup_reg: got %0d expected 12", bus.WriteReg); end
    applyStimulus(1'b1, 1'b0, 1'b1);
    checks += 4;
    if (bus.Count !== 4'd0) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 0", bus.Count); end
    if (bus.WriteReg !== 4'd0) begin errors++; $display("[TB] FAIL mid_reg: got %0d expected 0", bus.WriteReg); end
    if (bus.Empty !== 1'b1) begin errors++; $display("[TB] FAIL mid_empty: got %b expected 1", bus.Empty); end
    if (bus.Overflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_overflow: got %b expected 0", bus.Overflow); end
  endtask

  task automatic test_random();
    logic we, re, r;
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 59) == 0);
      applyStimulus(we, re, r);
      checks += 8;
      if (obsWrAcc !== expWrAcc) begin errors++; $display("[TB] FAIL rnd_wracc[%0d]: got %b expected %b", i, obsWrAcc, expWrAcc); end
      if (obsRdAcc !== expRdAcc) begin errors++; $display("[TB] FAIL rnd_rdacc[%0d]: got %b expected %b", i, obsRdAcc, expRdAcc); end
      if (obsSel !== expSel) begin errors++; $display("[TB] FAIL rnd_sel[%0d]: got %h expected %h", i, obsSel, expSel); end
      if (bus.Count !== 4'(mCount)) begin errors++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", i, bus.Count, mCount); end
      if (bus.WriteReg !== 4'(mAddr)) begin errors++; $display("[TB] FAIL rnd_reg[%0d]: got %0d expected %0d", i, bus.WriteReg, mAddr); end
      if (bus.Full !== (mCount == 15)) begin errors++; $display("[TB] FAIL rnd_full[%0d]: got %b expected %b", i, bus.Full, mCount == 15); end
      if (bus.Empty !== (mCount == 0)) begin errors++; $display("[TB] FAIL rnd_empty[%0d]: got %b expected %b", i, bus.Empty, mCount == 0); end
      if (bus.Overflow !== mOvf) begin errors++; $display("[TB] FAIL rnd_overflow[%0d]: got %b expected %b", i, bus.Overflow, mOvf); end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.WriteEn = 1'b0;
    bus.ReadEn  = 1'b0;
    test_reset();
    test_fill_wrap();
    test_drain();
    test_simultaneous();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
